step_trigger: RTL and testbench

//   Generates the "advance" events for the ACC control unit: the next button in

---
 rtl/step_trigger_pkg.sv | 21 ++
 rtl/step_trigger_btn_debounce.sv | 62 ++++++
 rtl/step_trigger.sv | 102 ++++++++++
 tb/tb_step_trigger.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_trigger_pkg.sv
// Shared constants and types for the step_trigger event generator.
package step_trigger_pkg;

    // Mode encoding as seen on mode_o
    localparam logic MANUAL_MODE    = 1'b1;
    localparam logic AUTOMATIC_MODE = 1'b0;

    // Auto-tick counter width presets (tick period = 2^N clocks)
    localparam int unsigned SLOW   = 24;
    localparam int unsigned MEDIUM = 22;
    localparam int unsigned FAST   = 20;

    // Debouncer states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait1 = 2'd1,
        StPulse = 2'd2,
        StWait0 = 2'd3
    } deb_state_e;

endpackage

// File: rtl/step_trigger_btn_debounce.sv
// Button debouncer: one single-clock pulse per press, however long or noisy
// the press is. The settle timer runs only while waiting.
module step_trigger_btn_debounce #(
    parameter int unsigned DEB_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    import step_trigger_pkg::*;

    deb_state_e          state_q, state_d;
    logic [DEB_BITS-1:0] timer_q, timer_d;
    logic [DEB_BITS-1:0] timer_inc;

    // Timer saturates once its MSB is set so a long hold in WAIT_0 cannot wrap
    assign timer_inc = timer_q[DEB_BITS-1] ? timer_q : timer_q + 1'b1;

    // Next-state and pulse decode; timer held at zero outside the wait states
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        pulse   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn) state_d = StWait1;
            end
            StWait1: begin
                timer_d = timer_inc;
                if (timer_inc[DEB_BITS-1]) begin
                    state_d = StPulse;
                    timer_d = '0;
                end
            end
            StPulse: begin
                pulse   = 1'b1;
                state_d = StWait0;
            end
            StWait0: begin
                timer_d = timer_inc;
                if (timer_inc[DEB_BITS-1] && !btn) begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/step_trigger.sv
// Advance-event generator for the ACC control unit: debounced next button in
// manual mode, periodic tick in automatic mode, with a one-deep buffer that
// holds an event until the core is ready.
module step_trigger
    import step_trigger_pkg::*;
#(
    parameter int unsigned DEB_BITS     = 16,
    parameter int unsigned SPEED_BITS   = MEDIUM,
    parameter logic        DEFAULT_MODE = MANUAL_MODE
) (
    input  logic clk,
    input  logic rst,
    input  logic next_in,
    input  logic selmode_in,
    input  logic ready_i,
    input  logic clr_ovr_i,
    output logic event_o,
    output logic mode_o,
    output logic pending_o,
    output logic overrun_o
);

    logic                  next_pulse, sel_pulse;
    logic [SPEED_BITS-1:0] cnt_q;
    logic                  msb_q;
    logic                  mode_q;
    logic                  tick, src;
    logic                  event_q, event_d;
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;

    step_trigger_btn_debounce #(
        .DEB_BITS (DEB_BITS)
    ) u_next_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (next_in),
        .pulse (next_pulse)
    );

    step_trigger_btn_debounce #(
        .DEB_BITS (DEB_BITS)
    ) u_sel_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (selmode_in),
        .pulse (sel_pulse)
    );

    // Rising edge of the counter MSB marks an auto tick
    assign tick = cnt_q[SPEED_BITS-1] & ~msb_q;
    assign src  = (mode_q == AUTOMATIC_MODE) ? tick : next_pulse;

    // Mode toggle, auto counter (restarted on every mode change) and MSB history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= DEFAULT_MODE;
            cnt_q  <= '0;
            msb_q  <= 1'b0;
        end else begin
            msb_q <= cnt_q[SPEED_BITS-1];
            if (sel_pulse) begin
                mode_q <= ~mode_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Delivery: a buffered event goes out first and a coincident new one takes
    // its place; a new event arriving on a full buffer while not ready is lost.
    always_comb begin
        event_d = 1'b0;
        pend_d  = pend_q | src;
        if (ready_i && (pend_q || src)) begin
            event_d = 1'b1;
            pend_d  = pend_q & src;
        end
        // Set has priority over clear
        ovr_d = (pend_q & src & ~ready_i) | (ovr_q & ~clr_ovr_i);
    end

    // Delivery registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_q <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            event_q <= event_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign event_o   = event_q;
    assign mode_o    = mode_q;
    assign pending_o = pend_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_step_trigger.sv
// Self-checking bench for step_trigger with DEB_BITS=3, SPEED_BITS=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// "edge e" is the e-th rising edge after reset release.
module tb_step_trigger;

    logic clk = 1'b0;
    logic rst, next_in, selmode_in, ready_i, clr_ovr_i;
    logic event_o, mode_o, pending_o, overrun_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    step_trigger #(
        .DEB_BITS     (3),
        .SPEED_BITS   (4),
        .DEFAULT_MODE (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .next_in    (next_in),
        .selmode_in (selmode_in),
        .ready_i    (ready_i),
        .clr_ovr_i  (clr_ovr_i),
        .event_o    (event_o),
        .mode_o     (mode_o),
        .pending_o  (pending_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, $signed(act),
                     $signed(exp), cyc);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        next_in    = 1'b0;
        selmode_in = 1'b0;
        ready_i    = 1'b0;
        clr_ovr_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    typedef struct {
        logic [15:0] pat;
        logic        rdy;
        int          exp_cnt;
        int          exp_first;
        logic        exp_pend;
    } vec_t;

    vec_t vecs[6];

    // Random-phase state
    bit sched_next[0:4095];
    bit sched_sel[0:4095];
    int nx_hi, nx_lo, sl_hi, sl_lo;
    int e, clear_edge, ev_cnt, first;
    bit m_mode, m_pend, m_ovr, m_evt, src, fire, new_ovr, rdy_lo_phase;

    initial begin
        // Press latency is 5 edges after the sampling edge of the first 1
        vecs[0] = '{16'h0001, 1'b1, 1, 5, 1'b0};  // single-clk press
        vecs[1] = '{16'hFFFF, 1'b1, 1, 5, 1'b0};  // long hold
        vecs[2] = '{16'hFFFD, 1'b1, 1, 5, 1'b0};  // bounce then hold
        vecs[3] = '{16'h0401, 1'b1, 2, 5, 1'b0};  // re-press right after IDLE
        vecs[4] = '{16'h0201, 1'b1, 1, 5, 1'b0};  // re-press one clk too early
        vecs[5] = '{16'h0001, 1'b0, 0, -1, 1'b1}; // not ready: buffered

        // Reset values
        do_reset();
        check("reset_event", event_o, 0);
        check("reset_pending", pending_o, 0);
        check("reset_overrun", overrun_o, 0);
        check("reset_mode", mode_o, 1);

        // Table-driven press patterns
        for (int v = 0; v < 6; v++) begin
            do_reset();
            ready_i = vecs[v].rdy;
            ev_cnt  = 0;
            first   = -1;
            for (int k = 0; k < 40; k++) begin
                next_in = (k < 16) ? vecs[v].pat[k] : 1'b0;
                step_clk();
                if (event_o === 1'b1) begin
                    ev_cnt++;
                    if (first < 0) first = k;
                end
            end
            check($sformatf("vec%0d_count", v), ev_cnt, vecs[v].exp_cnt);
            check($sformatf("vec%0d_first", v), first, vecs[v].exp_first);
            check($sformatf("vec%0d_pending", v), pending_o, vecs[v].exp_pend);
        end

        // Bounce for 3 clks then hold for 100: still one event
        do_reset();
        ready_i = 1'b1;
        ev_cnt  = 0;
        first   = -1;
        for (int k = 0; k < 125; k++) begin
            next_in = (k == 1) ? 1'b0 : (k < 103);
            step_clk();
            if (event_o === 1'b1) begin
                ev_cnt++;
                if (first < 0) first = k;
            end
        end
        check("hold100_count", ev_cnt, 1);
        check("hold100_first", first, 5);

        // Auto mode: mode flips at edge 6, ticks at edges 15, 31, 47; next ignored
        do_reset();
        ready_i = 1'b1;
        for (int k = 0; k < 60; k++) begin
            selmode_in = (k == 0);
            next_in    = (k == 20 || k == 40);
            step_clk();
            check("auto_mode", mode_o, (k >= 5) ? 0 : 1);
            check("auto_event", event_o, (k == 14 || k == 30 || k == 46) ? 1 : 0);
        end

        // Buffering while not ready
        do_reset();
        for (int k = 0; k < 8; k++) begin
            next_in = (k == 0);
            step_clk();
        end
        check("buf_pending", pending_o, 1);
        check("buf_no_event", event_o, 0);
        ready_i = 1'b1;
        step_clk();
        check("buf_event", event_o, 1);
        check("buf_pending_clr", pending_o, 0);
        step_clk();
        check("buf_event_once", event_o, 0);

        // Overrun, clear, and set-beats-clear
        do_reset();
        for (int k = 0; k < 32; k++) begin
            next_in   = (k == 0 || k == 12 || k == 24);
            clr_ovr_i = (k == 18 || k == 29);
            step_clk();
            check("ovr_no_event", event_o, 0);
            if (k == 16) check("ovr_before", overrun_o, 0);
            if (k == 17) check("ovr_set", overrun_o, 1);
            if (k == 17) check("ovr_pending", pending_o, 1);
            if (k == 18) check("ovr_cleared", overrun_o, 0);
            if (k == 18) check("ovr_pend_kept", pending_o, 1);
            if (k == 29) check("ovr_set_wins", overrun_o, 1);
            if (k == 30) check("ovr_sticky", overrun_o, 1);
        end

        // Asynchronous reset while pending and while next debouncer is waiting
        do_reset();
        for (int k = 0; k < 19; k++) begin
            selmode_in = (k == 0);
            next_in    = (k == 16);
            step_clk();
            if (k == 14) check("rst_pre_pending", pending_o, 1);
            if (k == 14) check("rst_pre_mode", mode_o, 0);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_event", event_o, 0);
        check("rst_async_pending", pending_o, 0);
        check("rst_async_overrun", overrun_o, 0);
        check("rst_async_mode", mode_o, 1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cyc     = 0;
        ready_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step_clk();
            check("post_rst_event", event_o, 0);
        end
        check("post_rst_mode", mode_o, 1);

        // Randomised run against a schedule-based reference model
        do_reset();
        for (int i = 0; i < 4096; i++) begin
            sched_next[i] = 1'b0;
            sched_sel[i]  = 1'b0;
        end
        nx_hi = 0; nx_lo = 0; sl_hi = 0; sl_lo = 0;
        m_mode = 1'b1; m_pend = 1'b0; m_ovr = 1'b0; m_evt = 1'b0;
        clear_edge   = 0;
        rdy_lo_phase = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            e = k + 1;
            // A clean press sampled at edge e yields a debounced pulse seen at e+5
            if (nx_hi > 0) begin
                next_in = 1'b1; nx_hi--;
            end else if (nx_lo > 0) begin
                next_in = 1'b0; nx_lo--;
            end else if ($urandom_range(0, 5) == 0) begin
                next_in = 1'b1;
                nx_hi = $urandom_range(0, 7);
                nx_lo = $urandom_range(12, 20);
                sched_next[e+5] = 1'b1;
            end else begin
                next_in = 1'b0;
            end
            if (sl_hi > 0) begin
                selmode_in = 1'b1; sl_hi--;
            end else if (sl_lo > 0) begin
                selmode_in = 1'b0; sl_lo--;
            end else if ($urandom_range(0, 79) == 0) begin
                selmode_in = 1'b1;
                sl_hi = $urandom_range(0, 7);
                sl_lo = $urandom_range(12, 20);
                sched_sel[e+5] = 1'b1;
            end else begin
                selmode_in = 1'b0;
            end
            if (k % 16 == 0) rdy_lo_phase = ($urandom_range(0, 2) == 0);
            ready_i   = rdy_lo_phase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            clr_ovr_i = ($urandom_range(0, 15) == 0);

            // Ticks land 9 edges after the last counter clear, then every 16
            if (m_mode)
                src = sched_next[e];
            else
                src = ((e - clear_edge) >= 9) && (((e - clear_edge - 9) % 16) == 0);
            fire    = ready_i && (m_pend || src);
            new_ovr = (m_pend && src && !ready_i) || (m_ovr && !clr_ovr_i);
            if (fire) m_pend = m_pend && src;
            else      m_pend = m_pend || src;
            m_evt = fire;
            m_ovr = new_ovr;
            if (sched_sel[e]) begin
                m_mode     = !m_mode;
                clear_edge = e;
            end

            step_clk();
            check("rnd_event", event_o, m_evt);
            check("rnd_pending", pending_o, m_pend);
            check("rnd_overrun", overrun_o, m_ovr);
            check("rnd_mode", mode_o, m_mode);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
